// File: rtl/detonator_pkg.sv
// Shared definitions for the beep pattern generator: FSM state encoding and
// default phase lengths (100 ms at 125 MHz).
package detonator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam int unsigned DEF_ON_CNT  = 12_500_000;
    localparam int unsigned DEF_OFF_CNT = 12_500_000;

endpackage

// File: rtl/beep_timer.sv
// 32-bit phase counter: counts up every cycle, can be cleared or loaded, and
// flags the last cycle of the current phase (ON or OFF compare value).
module beep_timer #(
    parameter logic [31:0] ON_LAST  = 32'd0,
    parameter logic [31:0] OFF_LAST = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        sel_off,
    output logic        tc
);

    logic [31:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 32'd0;
        end else if (clear) begin
            count <= 32'd0;
        end else if (load) begin
            count <= load_val;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign tc = (count == (sel_off ? OFF_LAST : ON_LAST));

endmodule

// File: rtl/beep_pattern_gen.sv
// Plays N beeps of ON_CNT cycles separated by OFF_CNT-cycle gaps; abort stops
// the pattern immediately without a done pulse.
module beep_pattern_gen
    import detonator_pkg::*;
#(
    parameter int unsigned ON_CNT  = DEF_ON_CNT,
    parameter int unsigned OFF_CNT = DEF_OFF_CNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] beep_num,
    input  logic       abort,
    output logic       beep_out,
    output logic       busy,
    output logic       done
);

    localparam logic [31:0] ON_LAST  = 32'(ON_CNT - 1);
    localparam logic [31:0] OFF_LAST = 32'(OFF_CNT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] rem_q;
    logic [3:0] rem_d;
    logic       phase_clr;
    logic       done_d;
    logic       tc;

    beep_timer #(
        .ON_LAST  (ON_LAST),
        .OFF_LAST (OFF_LAST)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (phase_clr),
        .load     (1'b0),
        .load_val (32'd0),
        .sel_off  (state_q == OFF),
        .tc       (tc)
    );

    // The counter is held at zero in IDLE and cleared on every phase change,
    // so each phase starts counting from 0 in its first cycle.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        phase_clr = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                phase_clr = 1'b1;
                if (start && (beep_num != 4'd0) && !abort) begin
                    state_d = ON;
                    rem_d   = beep_num;
                end
            end
            ON: begin
                if (abort) begin
                    state_d   = IDLE;
                    phase_clr = 1'b1;
                end else if (tc) begin
                    phase_clr = 1'b1;
                    rem_d     = rem_q - 4'd1;
                    if (rem_q != 4'd1) begin
                        state_d = OFF;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            OFF: begin
                if (abort) begin
                    state_d   = IDLE;
                    phase_clr = 1'b1;
                end else if (tc) begin
                    state_d   = ON;
                    phase_clr = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                phase_clr = 1'b1;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops
    // and line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rem_q    <= 4'd0;
            beep_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            beep_out <= (state_d == ON);
            busy     <= (state_d != IDLE);
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Bench for beep_pattern_gen: a fixed vector table, directed multi-cycle
// sequences and random traffic against a timeline-based reference model.
module tb_beep_pattern_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] beep_num;
    logic       abort;
    logic [1:0] beep_v;
    logic [1:0] busy_v;
    logic [1:0] done_v;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Two instances: the reference timing (4/3) and single-cycle phases (1/1).
    int on_c[2]  = '{4, 1};
    int off_c[2] = '{3, 1};

    // Model: last accepted pattern (start cycle, beep count) and whether it is
    // still allowed to play out (cleared by abort or reset).
    bit m_act[2];
    int m_t0[2];
    int m_n[2];

    beep_pattern_gen #(.ON_CNT(4), .OFF_CNT(3)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .beep_num (beep_num),
        .abort    (abort),
        .beep_out (beep_v[0]),
        .busy     (busy_v[0]),
        .done     (done_v[0])
    );

    beep_pattern_gen #(.ON_CNT(1), .OFF_CNT(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .beep_num (beep_num),
        .abort    (abort),
        .beep_out (beep_v[1]),
        .busy     (busy_v[1]),
        .done     (done_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [3:0] nm;
        logic       ab;
        logic       eb;
        logic       ebs;
        logic       ed;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pattern timeline: cycle k after the accepted start is busy for
    // k < N*ON + (N-1)*OFF, beeping in the first ON cycles of each period.
    function automatic void model_out(input int i, input int c,
                                      output logic b, output logic bs, output logic d);
        int k, per, len;
        b  = 1'b0;
        bs = 1'b0;
        d  = 1'b0;
        if (m_act[i]) begin
            k   = c - m_t0[i] - 1;
            per = on_c[i] + off_c[i];
            len = m_n[i] * on_c[i] + (m_n[i] - 1) * off_c[i];
            if (k >= 0 && k < len) begin
                bs = 1'b1;
                b  = ((k % per) < on_c[i]);
            end else if (k == len) begin
                d = 1'b1;
            end
        end
    endfunction

    task automatic drive(input logic st, input logic [3:0] nm, input logic ab);
        logic b, bs, d;
        start    = st;
        beep_num = nm;
        abort    = ab;
        for (int i = 0; i < 2; i++) begin
            model_out(i, cyc, b, bs, d);
            chk($sformatf("beep_out[%0d]", i), beep_v[i], b);
            chk($sformatf("busy[%0d]", i), busy_v[i], bs);
            chk($sformatf("done[%0d]", i), done_v[i], d);
            if (!rst) begin
                m_act[i] = 1'b0;
            end else if (bs && ab) begin
                m_act[i] = 1'b0;
            end else if (!bs && st && nm != 4'd0 && !ab) begin
                m_act[i] = 1'b1;
                m_t0[i]  = cyc;
                m_n[i]   = int'(nm);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        int   dcyc, beeps, bad, dseen, dmask, bmask, hi;
        logic prevb;

        tbl[0]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst      = 1'b0;
        start    = 1'b0;
        beep_num = 4'd0;
        abort    = 1'b0;
        m_act    = '{1'b0, 1'b0};
        m_t0     = '{0, 0};
        m_n      = '{0, 0};

        #2;
        for (int i = 0; i < 2; i++) begin
            chk("reset beep_out", beep_v[i], 1'b0);
            chk("reset busy", busy_v[i], 1'b0);
            chk("reset done", done_v[i], 1'b0);
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Two beeps, fixed vectors.
        for (int i = 0; i < 14; i++) begin
            chk("tbl beep_out", beep_v[0], tbl[i].eb);
            chk("tbl busy", busy_v[0], tbl[i].ebs);
            chk("tbl done", done_v[0], tbl[i].ed);
            drive(tbl[i].st, tbl[i].nm, tbl[i].ab);
        end
        idle(3);

        // Start while busy is ignored.
        dcyc = -1; beeps = 0; prevb = 1'b0;
        for (int c = 0; c < 23; c++) begin
            if (done_v[0]) dcyc = c;
            if (beep_v[0] && !prevb) beeps++;
            prevb = beep_v[0];
            drive(c == 0 || c == 6, (c == 6) ? 4'd5 : 4'd3, 1'b0);
        end
        chki("busy_start done cycle", dcyc, 19);
        chki("busy_start beep count", beeps, 3);
        idle(3);

        // Abort during the second ON phase.
        bad = 0; dseen = 0;
        for (int c = 0; c < 21; c++) begin
            if (c >= 10 && (beep_v[0] || busy_v[0])) bad++;
            if (done_v[0]) dseen++;
            drive(c == 0, 4'd3, c == 9);
        end
        chki("abort late activity", bad, 0);
        chki("abort done pulses", dseen, 0);
        idle(3);

        // beep_num = 0 is ignored.
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (beep_v[0] || busy_v[0] || done_v[0]) bad++;
            drive(c == 0, 4'd0, 1'b0);
        end
        chki("zero beeps activity", bad, 0);
        idle(2);

        // Restart in the done cycle.
        dmask = 0; bmask = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_v[0]) dmask |= (1 << c);
            if (beep_v[0]) bmask |= (1 << c);
            drive(c == 0 || c == 5, 4'd1, 1'b0);
        end
        chki("back_to_back done mask", dmask, (1 << 5) | (1 << 10));
        chki("back_to_back beep mask", bmask, 32'h3DE);
        idle(3);

        // Asynchronous reset in the middle of cycle 6.
        for (int c = 0; c < 6; c++) drive(c == 0, 4'd2, 1'b0);
        chk("pre-reset busy", busy_v[0], 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk("async reset beep_out", beep_v[0], 1'b0);
        chk("async reset busy", busy_v[0], 1'b0);
        chk("async reset done", done_v[0], 1'b0);
        m_act = '{1'b0, 1'b0};
        @(posedge clk);
        #1;
        cyc++;
        drive(1'b0, 4'd0, 1'b0);
        rst = 1'b1;
        hi = 0; dcyc = -1;
        for (int c = 0; c < 15; c++) begin
            if (beep_v[0]) hi++;
            if (done_v[0]) dcyc = c;
            drive(c == 0, 4'd2, 1'b0);
        end
        chki("post-reset beep cycles", hi, 8);
        chki("post-reset done cycle", dcyc, 12);
        idle(2);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beep_pattern_gen.md
BEEP_PATTERN_GEN -- requirements
Module: beep_pattern_gen

Interface
REQ-001 The block SHALL have parameter ON_CNT, default 12_500_000, meaning beep-on duration in clk cycles (100 ms at 125 MHz).
REQ-002 The block SHALL have parameter OFF_CNT, default 12_500_000, meaning inter-beep gap in clk cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to play a pattern.
REQ-006 The block SHALL have port beep_num, input, 4 bits: number of beeps to play (1..15), sampled with start.
REQ-007 The block SHALL have port abort, input, 1 bit: stops the pattern immediately.
REQ-008 The block SHALL have port beep_out, output, 1 bit: registered buzzer/LED drive, high = on.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a pattern is playing.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ON, OFF.
REQ-012 In IDLE, start=1 with beep_num!=0 and abort=0 SHALL latch beep_num into a 4-bit remaining count, clear the phase counter and enter ON at the next edge.
REQ-013 start with beep_num=0 SHALL be ignored: no state change and no done pulse.
REQ-014 start while busy=1 SHALL be ignored, and the latched beep_num SHALL be unchanged.
REQ-015 beep_out SHALL be 1 exactly while the state is ON, so it first rises in the cycle after the accepted start.
REQ-016 Each ON phase SHALL last exactly ON_CNT cycles and each OFF phase exactly OFF_CNT cycles, timed by a 32-bit phase counter that restarts at 0 on every phase entry.
REQ-017 At the end of ON, the block SHALL decrement the remaining count; if the result is nonzero it SHALL enter OFF, otherwise it SHALL enter IDLE.
REQ-018 At the end of OFF, the block SHALL enter ON.
REQ-019 No OFF phase SHALL follow the last beep, so total busy time SHALL be N*ON_CNT + (N-1)*OFF_CNT cycles.
REQ-020 busy SHALL be 1 exactly when the state is not IDLE.
REQ-021 done SHALL pulse for one cycle in the first IDLE cycle after a normally completed last ON phase.
REQ-022 A start in the done cycle SHALL be accepted, since busy=0 then.
REQ-023 abort=1 in ON or OFF SHALL force IDLE at the next edge with beep_out=0 and busy=0, and SHALL produce no done pulse.
REQ-024 When abort and start are both high in IDLE, abort SHALL win and start SHALL be ignored.
REQ-025 The phase counter SHALL compare against ON_CNT-1 and OFF_CNT-1; both parameters SHALL be >=1, with 1 giving single-cycle phases.

Reset
REQ-026 rst=0 SHALL asynchronously force state IDLE, beep_out=0, busy=0, done=0, remaining count 0 and phase counter 0.
REQ-027 Reset asserted mid-pattern SHALL abandon the pattern with no done pulse.
REQ-028 After reset release, the first start SHALL be accepted no earlier than the first rising clk edge.

Structure
REQ-029 The shared package detonator_pkg SHALL hold the state encodings (IDLE, ON, OFF, 2 bits) and the default ON_CNT/OFF_CNT constants.
REQ-030 The design SHALL use one sub-module, beep_timer: a 32-bit loadable phase counter with clear and terminal-count output, parameterised by the compare value.
REQ-031 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Verification (ON_CNT=4, OFF_CNT=3, start at cycle 0)
REQ-032 Stimulus: beep_num=2. Required response: beep_out=1 in cycles 1-4 and 8-11, 0 in cycles 5-7; busy=1 in cycles 1-11; done=1 in cycle 12 only.
REQ-033 Stimulus: beep_num=3, with a second start and beep_num=5 at cycle 6. Required response: the second start is ignored; the pattern is exactly 3 beeps; done in cycle 19.
REQ-034 Stimulus: beep_num=3, abort at cycle 9 (during the second ON). Required response: beep_out=0 and busy=0 from cycle 10; done never asserts.
REQ-035 Stimulus: beep_num=0. Required response: busy, beep_out and done stay 0 for 20 cycles.
REQ-036 Stimulus: beep_num=2, rst=0 asynchronously mid-cycle 6. Required response: all outputs 0 immediately, without waiting for a clock edge; a new start after release plays a full pattern.
REQ-037 Stimulus: beep_num=1 at cycle 0, then start with beep_num=1 in done cycle 5. Required response: beep_out=1 in cycles 1-4 and 6-9; done in cycles 5 and 10.
